// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared constants for the pong video timing chain:
//   - controller state encoding (RUN / PENDING / HOLD)
//   - mode index constants, with MODE_INVALID marking the unused table slot
//   - per-mode horizontal and vertical timing values (sync/front/active/back)
//   - mode_is_valid() helper for screening incoming mode requests
package video_timing_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [1:0] MODE_640X480 = 2'd0;
  localparam logic [1:0] MODE_800X600 = 2'd1;
  localparam logic [1:0] MODE_640X350 = 2'd2;
  localparam logic [1:0] MODE_INVALID = 2'd3;

  // mode 0: 640x480
  localparam int M0_H_SYNC = 96,  M0_H_FRONT = 16, M0_H_ACTIVE = 640, M0_H_BACK = 48;
  localparam int M0_V_SYNC = 2,   M0_V_FRONT = 10, M0_V_ACTIVE = 480, M0_V_BACK = 33;
  // mode 1: 800x600
  localparam int M1_H_SYNC = 128, M1_H_FRONT = 40, M1_H_ACTIVE = 800, M1_H_BACK = 88;
  localparam int M1_V_SYNC = 4,   M1_V_FRONT = 1,  M1_V_ACTIVE = 600, M1_V_BACK = 23;
  // mode 2: 640x350
  localparam int M2_H_SYNC = 96,  M2_H_FRONT = 16, M2_H_ACTIVE = 640, M2_H_BACK = 48;
  localparam int M2_V_SYNC = 2,   M2_V_FRONT = 37, M2_V_ACTIVE = 350, M2_V_BACK = 60;

  function automatic logic mode_is_valid(input logic [1:0] mode);
    return mode != MODE_INVALID;
  endfunction

endpackage

// File: rtl/video_mode_table.sv
// video_mode_table
// Combinational ROM: 2-bit mode index -> eight timing values + valid flag.
// Ports:
//   mode                          in   mode index
//   h_sync/h_front/h_active/h_back out  horizontal timing (XW bits)
//   v_sync/v_front/v_active/v_back out  vertical timing (YW bits)
//   valid                         out  mode index names a real table entry
// The invalid slot returns mode 0 values with valid=0 so the outputs are
// never undefined.
module video_mode_table
  import video_timing_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic [1:0]    mode,
  output logic [XW-1:0] h_sync,
  output logic [XW-1:0] h_front,
  output logic [XW-1:0] h_active,
  output logic [XW-1:0] h_back,
  output logic [YW-1:0] v_sync,
  output logic [YW-1:0] v_front,
  output logic [YW-1:0] v_active,
  output logic [YW-1:0] v_back,
  output logic          valid
);

  always_comb begin
    h_sync   = XW'(M0_H_SYNC);
    h_front  = XW'(M0_H_FRONT);
    h_active = XW'(M0_H_ACTIVE);
    h_back   = XW'(M0_H_BACK);
    v_sync   = YW'(M0_V_SYNC);
    v_front  = YW'(M0_V_FRONT);
    v_active = YW'(M0_V_ACTIVE);
    v_back   = YW'(M0_V_BACK);
    valid    = 1'b0;
    case (mode)
      MODE_640X480: valid = 1'b1;
      MODE_800X600: begin
        h_sync   = XW'(M1_H_SYNC);
        h_front  = XW'(M1_H_FRONT);
        h_active = XW'(M1_H_ACTIVE);
        h_back   = XW'(M1_H_BACK);
        v_sync   = YW'(M1_V_SYNC);
        v_front  = YW'(M1_V_FRONT);
        v_active = YW'(M1_V_ACTIVE);
        v_back   = YW'(M1_V_BACK);
        valid    = 1'b1;
      end
      MODE_640X350: begin
        h_sync   = XW'(M2_H_SYNC);
        h_front  = XW'(M2_H_FRONT);
        h_active = XW'(M2_H_ACTIVE);
        h_back   = XW'(M2_H_BACK);
        v_sync   = YW'(M2_V_SYNC);
        v_front  = YW'(M2_V_FRONT);
        v_active = YW'(M2_V_ACTIVE);
        v_back   = YW'(M2_V_BACK);
        valid    = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/video_mode_controller.sv
// video_mode_controller
// Sequences video-mode changes for the pong display timing chain.
// Ports:
//   clock, reset        pixel clock, synchronous active-high reset
//   ModeRequest/ModeLoad mode change request (strobe samples request)
//   FrameEnd            last-pixel-of-frame pulse from the vertical chain
//   H*/V* timing buses  registered timing for the sync modules
//   SyncReset           holds the sync modules in reset during restart
//   ModeActive          mode currently on the buses
//   Busy                change pending or restart in progress
//   ModeError           sticky flag for requests of the invalid mode
//   FrameCount          frames since last restart (wraps)
//   GameTick            game-update pulse every TICK_DIVIDE frames
// A requested mode is parked in PENDING and only applied on FrameEnd, so a
// frame is never torn. HOLD keeps SyncReset high for HOLD_CYCLES cycles.
module video_mode_controller
  import video_timing_pkg::*;
#(
  parameter int xresolution = 11,
  parameter int yresolution = 10,
  parameter int HOLD_CYCLES = 4,
  parameter int TICK_DIVIDE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             ModeRequest,
  input  logic                   ModeLoad,
  input  logic                   FrameEnd,
  output logic [xresolution-1:0] HSynchPulse,
  output logic [xresolution-1:0] HFrontPorch,
  output logic [xresolution-1:0] HActiveVideo,
  output logic [xresolution-1:0] HBackPorch,
  output logic [yresolution-1:0] VSynchPulse,
  output logic [yresolution-1:0] VFrontPorch,
  output logic [yresolution-1:0] VActiveVideo,
  output logic [yresolution-1:0] VBackPorch,
  output logic                   SyncReset,
  output logic [1:0]             ModeActive,
  output logic                   Busy,
  output logic                   ModeError,
  output logic [7:0]             FrameCount,
  output logic                   GameTick
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TCW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;

  logic [1:0]             state;
  logic [HCW-1:0]         hold_cnt;
  logic [TCW-1:0]         tick_cnt;
  logic [1:0]             pending_mode;
  logic [xresolution-1:0] t_h_sync, t_h_front, t_h_active, t_h_back;
  logic [yresolution-1:0] t_v_sync, t_v_front, t_v_active, t_v_back;
  logic                   t_valid;
  logic                   req_ok;

  // The ROM is addressed by the pending mode: that is the only mode ever
  // loaded onto the buses (at HOLD entry).
  video_mode_table #(.XW(xresolution), .YW(yresolution)) u_table (
    .mode     (pending_mode),
    .h_sync   (t_h_sync),
    .h_front  (t_h_front),
    .h_active (t_h_active),
    .h_back   (t_h_back),
    .v_sync   (t_v_sync),
    .v_front  (t_v_front),
    .v_active (t_v_active),
    .v_back   (t_v_back),
    .valid    (t_valid)
  );

  assign req_ok = mode_is_valid(ModeRequest);
  assign Busy   = (state != ST_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_HOLD;
      hold_cnt     <= '0;
      tick_cnt     <= '0;
      pending_mode <= MODE_640X480;
      ModeActive   <= MODE_640X480;
      SyncReset    <= 1'b1;
      ModeError    <= 1'b0;
      FrameCount   <= 8'd0;
      GameTick     <= 1'b0;
      HSynchPulse  <= xresolution'(M0_H_SYNC);
      HFrontPorch  <= xresolution'(M0_H_FRONT);
      HActiveVideo <= xresolution'(M0_H_ACTIVE);
      HBackPorch   <= xresolution'(M0_H_BACK);
      VSynchPulse  <= yresolution'(M0_V_SYNC);
      VFrontPorch  <= yresolution'(M0_V_FRONT);
      VActiveVideo <= yresolution'(M0_V_ACTIVE);
      VBackPorch   <= yresolution'(M0_V_BACK);
    end else begin
      GameTick <= 1'b0;
      // Invalid requests are flagged in RUN and PENDING, even when the same
      // cycle also carries the FrameEnd that starts a restart.
      if (state != ST_HOLD && ModeLoad && !req_ok) ModeError <= 1'b1;
      case (state)
        ST_RUN: begin
          if (FrameEnd) begin
            FrameCount <= FrameCount + 8'd1;
            if (tick_cnt == TCW'(TICK_DIVIDE - 1)) begin
              tick_cnt <= '0;
              GameTick <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          if (ModeLoad && req_ok && ModeRequest != ModeActive) begin
            pending_mode <= ModeRequest;
            state        <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          // The frame that triggers the restart neither ticks nor counts:
          // counter and divider both restart from zero here.
          if (FrameEnd) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            SyncReset  <= 1'b1;
            ModeActive <= pending_mode;
            FrameCount <= 8'd0;
            tick_cnt   <= '0;
            if (t_valid) begin
              HSynchPulse  <= t_h_sync;
              HFrontPorch  <= t_h_front;
              HActiveVideo <= t_h_active;
              HBackPorch   <= t_h_back;
              VSynchPulse  <= t_v_sync;
              VFrontPorch  <= t_v_front;
              VActiveVideo <= t_v_active;
              VBackPorch   <= t_v_back;
            end
          end else if (ModeLoad && req_ok) begin
            pending_mode <= ModeRequest;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
            state     <= ST_RUN;
            SyncReset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back into a clean restart.
          state     <= ST_HOLD;
          hold_cnt  <= '0;
          SyncReset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_controller.sv
// Testbench for video_mode_controller: directed scenarios followed by random
// traffic, every cycle compared against a frame-level behavioural model.
module tb_video_mode_controller;

  localparam int XW = 11, YW = 10, HOLD = 4, TD = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    ModeRequest = 2'd0;
  logic          ModeLoad = 1'b0;
  logic          FrameEnd = 1'b0;
  logic [XW-1:0] HSynchPulse, HFrontPorch, HActiveVideo, HBackPorch;
  logic [YW-1:0] VSynchPulse, VFrontPorch, VActiveVideo, VBackPorch;
  logic          SyncReset, Busy, ModeError, GameTick;
  logic [1:0]    ModeActive;
  logic [7:0]    FrameCount;

  video_mode_controller #(
    .xresolution(XW), .yresolution(YW), .HOLD_CYCLES(HOLD), .TICK_DIVIDE(TD)
  ) dut (
    .clock(clock), .reset(reset), .ModeRequest(ModeRequest), .ModeLoad(ModeLoad),
    .FrameEnd(FrameEnd), .HSynchPulse(HSynchPulse), .HFrontPorch(HFrontPorch),
    .HActiveVideo(HActiveVideo), .HBackPorch(HBackPorch), .VSynchPulse(VSynchPulse),
    .VFrontPorch(VFrontPorch), .VActiveVideo(VActiveVideo), .VBackPorch(VBackPorch),
    .SyncReset(SyncReset), .ModeActive(ModeActive), .Busy(Busy), .ModeError(ModeError),
    .FrameCount(FrameCount), .GameTick(GameTick)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // mode table, indexed by mode number
  int hs[3] = '{96, 128, 96};
  int hf[3] = '{16, 40, 16};
  int ha[3] = '{640, 800, 640};
  int hb[3] = '{48, 88, 48};
  int vs[3] = '{2, 4, 2};
  int vf[3] = '{10, 1, 37};
  int va[3] = '{480, 600, 350};
  int vb[3] = '{33, 23, 60};

  // model: mode on the buses, an optional parked request, remaining
  // restart cycles, and frame/tick bookkeeping as plain integers
  int m_active, m_pend, m_hold_left, m_frames, m_div;
  bit m_pending, m_err, m_tick;

  task automatic model(input bit rst, input bit ld, input int req, input bit fe);
    if (rst) begin
      m_active = 0; m_pend = 0; m_pending = 0; m_hold_left = HOLD;
      m_err = 0; m_frames = 0; m_div = 0; m_tick = 0;
      return;
    end
    m_tick = 0;
    if (m_hold_left > 0) begin
      m_hold_left--;
      return;
    end
    if (ld && req == 3) m_err = 1;
    if (!m_pending) begin
      if (fe) begin
        m_frames = (m_frames + 1) % 256;
        m_div++;
        if (m_div == TD) begin m_tick = 1; m_div = 0; end
      end
      if (ld && req != 3 && req != m_active) begin m_pending = 1; m_pend = req; end
    end else if (fe) begin
      m_active = m_pend; m_pending = 0; m_hold_left = HOLD; m_frames = 0; m_div = 0;
    end else if (ld && req != 3) begin
      m_pend = req;
    end
  endtask

  task automatic compare();
    chk("sync_reset", SyncReset, m_hold_left > 0);
    chk("busy", Busy, m_pending || m_hold_left > 0);
    chk("mode_active", ModeActive, m_active);
    chk("mode_error", ModeError, m_err);
    chk("frame_count", FrameCount, m_frames);
    chk("game_tick", GameTick, m_tick);
    chk("h_sync", HSynchPulse, hs[m_active]);
    chk("h_front", HFrontPorch, hf[m_active]);
    chk("h_active", HActiveVideo, ha[m_active]);
    chk("h_back", HBackPorch, hb[m_active]);
    chk("v_sync", VSynchPulse, vs[m_active]);
    chk("v_front", VFrontPorch, vf[m_active]);
    chk("v_active", VActiveVideo, va[m_active]);
    chk("v_back", VBackPorch, vb[m_active]);
  endtask

  task automatic step(input bit rst, input bit ld, input int req, input bit fe);
    @(negedge clock);
    reset = rst; ModeLoad = ld; ModeRequest = req[1:0]; FrameEnd = fe;
    @(posedge clock);
    model(rst, ld, req, fe);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  initial begin
    // reset and release
    repeat (3) step(1, 0, 0, 0);
    idle(8);
    // switch to mode 1, FrameEnd 100 cycles later
    step(0, 1, 1, 0);
    idle(99);
    step(0, 0, 0, 1);
    idle(8);
    chk("dir_mode1_hactive", HActiveVideo, 800);
    // two requests before the frame boundary: last wins
    step(0, 1, 0, 0);
    idle(5);
    step(0, 1, 2, 0);
    idle(5);
    step(0, 0, 0, 1);
    idle(8);
    chk("dir_last_wins", ModeActive, 2);
    // invalid request: sticky error, no restart
    step(0, 1, 3, 0);
    idle(6);
    chk("dir_err_sticky", ModeError, 1);
    // load and FrameEnd together: switch on the following FrameEnd
    step(0, 1, 0, 1);
    idle(10);
    step(0, 0, 0, 1);
    idle(8);
    chk("dir_same_cycle", ModeActive, 0);
    // fresh divider: 9 frames -> 3 ticks
    repeat (2) step(1, 0, 0, 0);
    idle(6);
    repeat (9) begin
      step(0, 0, 0, 1);
      idle(2);
    end
    chk("dir_nine_frames", FrameCount, 9);
    // FrameCount wrap
    repeat (250) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    chk("dir_wrap", FrameCount, 3);
    // random traffic
    repeat (3000) begin
      step($urandom % 400 == 0, $urandom % 8 == 0, int'($urandom % 4), $urandom % 16 == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
